// File: rtl/slow_tick_debounce_if.sv
// slow_tick_debounce_if: slow-clock/raw-input bundle and debounced results.
// master drives slow_clk and raw_in; slave (the debouncer) drives the rest.
interface slow_tick_debounce_if #(
  parameter int WIDTH = 4
);
  logic             slow_clk;
  logic [WIDTH-1:0] raw_in;
  logic             tick_en;
  logic [WIDTH-1:0] deb_out;
  logic [WIDTH-1:0] deb_rise;
  logic [WIDTH-1:0] deb_fall;
  logic             busy_timeout;

  modport master (
    output slow_clk,
    output raw_in,
    input  tick_en,
    input  deb_out,
    input  deb_rise,
    input  deb_fall,
    input  busy_timeout
  );

  modport slave (
    input  slow_clk,
    input  raw_in,
    output tick_en,
    output deb_out,
    output deb_rise,
    output deb_fall,
    output busy_timeout
  );
endinterface

// File: rtl/slow_tick_debounce.sv
// slow_tick_debounce: slow_clk edge -> tick_en strobe, tick-paced debounce
// of WIDTH active-low inputs with edge pulses, and R/B# busy watchdog.
module slow_tick_debounce #(
  parameter int WIDTH     = 4,
  parameter int DEB_TICKS = 3,
  parameter int TO_TICKS  = 100
) (
  input  logic                cpld_50m_clk,
  input  logic                cpld_rst_50m,
  slow_tick_debounce_if.slave bus
);
  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam int TW = $clog2(TO_TICKS + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TO_TICKS);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic             r_slow_d;
  logic             r_tick;
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [TW-1:0]    r_to_cnt;
  logic             r_busy;

  // slow_d resets high so a slow_clk already high at release is no edge
  always_ff @(posedge cpld_50m_clk) begin
    if (cpld_rst_50m) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_slow_d <= 1'b1;
      r_tick   <= 1'b0;
    end else begin
      r_sync1  <= bus.raw_in;
      r_sync2  <= r_sync1;
      r_slow_d <= bus.slow_clk;
      r_tick   <= bus.slow_clk & ~r_slow_d;
    end
  end

  // any agreeing cycle clears the count, so only unbroken
  // disagreement across DEB_TICKS ticks flips a level
  always_ff @(posedge cpld_50m_clk) begin
    if (cpld_rst_50m) begin
      r_deb  <= '1;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_tick && r_cnt[i] == DEB_LAST) begin
          r_deb[i]  <= r_sync2[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= r_sync2[i];
          r_fall[i] <= ~r_sync2[i];
        end else if (r_tick) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // watchdog counts ticks while R/B# is debounced low; the
  // flag is sticky until R/B# returns high
  always_ff @(posedge cpld_50m_clk) begin
    if (cpld_rst_50m) begin
      r_to_cnt <= '0;
      r_busy   <= 1'b0;
    end else if (r_deb[0]) begin
      r_to_cnt <= '0;
      r_busy   <= 1'b0;
    end else if (r_tick && r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + TW'(1);
      if (r_to_cnt == TO_MAX - TW'(1)) begin
        r_busy <= 1'b1;
      end
    end
  end

  assign bus.tick_en      = r_tick;
  assign bus.deb_out      = r_deb;
  assign bus.deb_rise     = r_rise;
  assign bus.deb_fall     = r_fall;
  assign bus.busy_timeout = r_busy;
endmodule

// File: doc/slow_tick_debounce.md
# slow_tick_debounce

Consumer of the divided slow clock (`count[19]` of the 50 MHz free-running divider, period 2^20 cycles ≈ 20.97 ms) on the NAND-flash interface CPLD. It converts the slow square wave into a one-cycle `tick_en` strobe in the `cpld_50m_clk` domain. It uses that strobe to debounce WIDTH raw asynchronous inputs (NAND R/B#, service buttons) and emits clean levels plus edge pulses. It also runs a tick-based busy-timeout watchdog on bit 0 (R/B#).

## Interface
Parameters:
- WIDTH, 4, number of debounced inputs (≥1)
- DEB_TICKS, 3, consecutive ticks an input must disagree with its debounced level before the level flips (≥1)
- TO_TICKS, 100, ticks `deb_out[0]` may stay low before `busy_timeout` asserts (≥1; 100 ≈ 2.1 s)

Ports (one clock; reset is synchronous and active-high):
- cpld_50m_clk  in  1  50 MHz system clock, all logic on rising edge
- cpld_rst_50m  in  1  synchronous active-high reset
- slow_clk  in  1  divided square wave from the clock divider, same clock domain
- raw_in  in  WIDTH  raw asynchronous inputs, active-low, idle high
- tick_en  out  1  one-cycle strobe per slow_clk rising edge
- deb_out  out  WIDTH  debounced levels
- deb_rise  out  WIDTH  one-cycle pulse when a deb_out bit goes 0→1
- deb_fall  out  WIDTH  one-cycle pulse when a deb_out bit goes 1→0
- busy_timeout  out  1  sticky flag: deb_out[0] low for TO_TICKS ticks

## Operation
- Reset values: deb_out = all ones; deb_rise, deb_fall, tick_en, busy_timeout = 0. All debounce counters and the timeout counter = 0. Synchronizer flops = all ones. slow_d = 1, so no spurious tick occurs if slow_clk is high at release.
- Synchronizer: raw_in passes through 2 flops (sync1 → sync2). Only sync2 is used downstream.
- Tick: slow_d <= slow_clk; tick_en <= slow_clk & ~slow_d (registered).
- Per-bit debounce, counter width clog2(DEB_TICKS+1):
  - If sync2[i] == deb_out[i]: cnt[i] <= 0. This takes priority every cycle, so any single agreeing cycle restarts the count.
  - Else if tick_en and cnt[i] == DEB_TICKS-1: deb_out[i] <= sync2[i], cnt[i] <= 0, and the matching deb_rise/deb_fall bit pulses for that one cycle. The pulse is registered and coincident with the deb_out update.
  - Else if tick_en: cnt[i] <= cnt[i]+1.
  - Bits are independent. Multiple bits may flip in the same cycle.
- Timeout, bit 0 only:
  - If deb_out[0] == 1: to_cnt <= 0, busy_timeout <= 0. This has priority over a simultaneous tick.
  - Else on tick_en: to_cnt increments, saturating at TO_TICKS. busy_timeout <= 1 on the tick where to_cnt reaches TO_TICKS.
  - busy_timeout stays high until deb_out[0] returns high or reset.
- A reset asserted mid-operation aborts all counts and restores reset values on the next edge.

## Timing
- tick_en is high in cycle n+2 when slow_clk first reads 1 at edge n+1 after reading 0 at edge n. With the 2^20 divider, one strobe occurs every 1,048,576 cycles.
- Input latency: 2 synchronizer cycles, then DEB_TICKS ticks of continuous disagreement. The flip occurs in the same cycle as the DEB_TICKS-th counted tick_en.
- Worst case, from the raw change to deb_out: 2 cycles + DEB_TICKS tick periods. Best case: 2 cycles + (DEB_TICKS-1) tick periods + 1 cycle.
- deb_rise/deb_fall are exactly one cycle wide and never both set for the same bit.
- busy_timeout rises on the TO_TICKS-th tick after deb_out[0] falls; the falling cycle itself is not counted. It falls one cycle after deb_out[0] rises, i.e. on the next edge.

## Test plan
Bench uses a local slow_clk square wave with a 64-cycle period unless noted; DEB_TICKS=3, TO_TICKS=5.
- Reset with slow_clk=1 for 5 cycles, then release → deb_out=4'hF, all pulses/flags 0, no tick_en within 32 cycles after release.
- Free-running slow_clk → tick_en high exactly 1 cycle per rising edge, spaced 64 cycles; rising edge at edge n gives tick_en at n+2 (verify once).
- raw_in[1] toggles every 10 cycles for 3 tick periods, then held 0 → deb_out[1] stays 1 while bouncing. It falls on the 3rd tick after the last bounce, with deb_fall[1] a 1-cycle pulse; other bits unchanged.
- raw_in[2] held low for exactly 2 tick periods, then high → deb_out[2] never changes, no pulses; the counter restarts (next low requires 3 full ticks).
- raw_in[0] held low → deb_out[0] falls at the 3rd tick; busy_timeout rises 5 ticks later. Raise raw_in[0] → deb_out[0] rises after 3 ticks and busy_timeout clears on the next edge.
- raw_in[3] low with 2 ticks counted, assert cpld_rst_50m 1 cycle → all outputs back to reset values; after release deb_out[3] needs 3 fresh ticks to fall.
